// File: rtl/rv32i_pkg.sv
// Shared constants for the rv32i fetch path.
package rv32i_pkg;

   // Architectural word / instruction width.
   localparam int unsigned XLEN = 32;

   // Default first fetch address after reset.
   localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

   // Byte distance between consecutive sequential fetches.
   localparam int unsigned FETCH_INC = 4;

endpackage

// File: rtl/pfu_fifo.sv
// Synchronous instruction buffer FIFO with flush, used by the prefetch unit.
// Storage is not reset; only pointers and the occupancy count are.
module pfu_fifo #(
   parameter int unsigned W     = 65,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   resetb_i,
   input  logic                   clk_en_i,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [W-1:0]           wdata_i,
   input  logic                   pop_i,
   output logic [W-1:0]           rdata_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o,
   output logic                   full_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Flush wins over push and pop; a push into a full FIFO only lands alongside a pop.
   always_comb begin
      do_pop   = pop_i & ~empty_o & ~flush_i;
      do_push  = push_i & (~full_o | do_pop) & ~flush_i;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk_i or negedge resetb_i) begin
      if (!resetb_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clk_en_i) begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage, written at the tail on an accepted push.
   always_ff @(posedge clk_i) begin
      if (clk_en_i && do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/pfu.sv
// Prefetch unit: sequential instruction fetch with credit-based flow control,
// a small buffer of {instruction, pc, bus error} toward decode, and PC redirects
// that flush the buffer and drop responses still in flight.
module pfu
   import rv32i_pkg::*;
#(
   parameter int unsigned         C_XLEN         = XLEN,
   parameter int unsigned         C_FIFO_DEPTH   = 4,
   parameter logic [C_XLEN-1:0]   C_RESET_VECTOR = C_XLEN'(RESET_VECTOR)
) (
   input  logic              clk_i,
   input  logic              resetb_i,
   input  logic              clk_en_i,
   output logic              pc_ready_o,
   input  logic              pc_wr_i,
   input  logic [C_XLEN-1:0] pc_i,
   output logic              ireqvalid_o,
   input  logic              ireqready_i,
   output logic [C_XLEN-1:0] ireqaddr_o,
   input  logic              irspvalid_i,
   input  logic [C_XLEN-1:0] irspdata_i,
   input  logic              irsperr_i,
   output logic              ids_dav_o,
   input  logic              ids_ack_i,
   output logic [C_XLEN-1:0] ids_ins_o,
   output logic [C_XLEN-1:0] ids_pc_o,
   output logic              ids_ferr_o
);

   // Counters must hold a full buffer's worth of live requests plus a full
   // buffer's worth of requests still to be discarded after a redirect.
   localparam int unsigned       CW         = $clog2(2 * C_FIFO_DEPTH) + 1;
   localparam int unsigned       FCW        = $clog2(C_FIFO_DEPTH) + 1;
   localparam int unsigned       EW         = 2 * C_XLEN + 1;
   localparam logic [C_XLEN-1:0] ALIGN_MASK = ~C_XLEN'(3);
   localparam logic [C_XLEN-1:0] INC        = C_XLEN'(FETCH_INC);

   logic              run_q;
   logic [C_XLEN-1:0] fpc_q, fpc_d;
   logic [C_XLEN-1:0] rpc_q, rpc_d;
   logic [CW-1:0]     outst_q, outst_d;
   logic [CW-1:0]     disc_q, disc_d;
   logic [CW-1:0]     credit_sum;
   logic [C_XLEN-1:0] target;
   logic              req_acc, redirect;
   logic              push_req, push, fifo_pop;
   logic [FCW-1:0]    fifo_count;
   logic              fifo_empty, fifo_full;
   logic [EW-1:0]     fifo_wdata, fifo_rdata;

   // Words the buffer is already committed to: buffered plus live (non-discarded) requests.
   assign credit_sum  = CW'(fifo_count) + outst_q - disc_q;
   assign ireqvalid_o = run_q & (credit_sum < CW'(C_FIFO_DEPTH));
   assign ireqaddr_o  = fpc_q & ALIGN_MASK;
   assign pc_ready_o  = ~(ireqvalid_o & ~ireqready_i);
   assign req_acc     = ireqvalid_o & ireqready_i;
   assign redirect    = pc_wr_i & pc_ready_o;
   assign target      = pc_i & ALIGN_MASK;

   // A response is kept only when nothing is left to discard and no redirect
   // happens this cycle; the full guard is a backstop behind the credit rule.
   assign push_req   = irspvalid_i & (disc_q == '0) & ~redirect;
   assign fifo_pop   = ids_dav_o & ids_ack_i;
   assign push       = push_req & (~fifo_full | fifo_pop);
   assign fifo_wdata = {irspdata_i, rpc_q & ALIGN_MASK, irsperr_i};

   assign ids_dav_o = ~fifo_empty;
   assign {ids_ins_o, ids_pc_o, ids_ferr_o} = fifo_rdata;

   // Next-state for fetch/response PCs and the outstanding/discard counters.
   always_comb begin
      fpc_d   = fpc_q;
      rpc_d   = rpc_q;
      disc_d  = disc_q;
      outst_d = outst_q + CW'(req_acc) - CW'(irspvalid_i);
      if (req_acc) fpc_d = fpc_q + INC;
      if (irspvalid_i) begin
         if (disc_q != '0) disc_d = disc_q - CW'(1);
         else              rpc_d  = rpc_q + INC;
      end
      if (redirect) begin
         fpc_d  = target;
         rpc_d  = target;
         disc_d = outst_d;
      end
   end

   // Control state; run_q keeps the request port quiet in the first cycle after reset.
   always_ff @(posedge clk_i or negedge resetb_i) begin
      if (!resetb_i) begin
         run_q   <= 1'b0;
         fpc_q   <= C_RESET_VECTOR;
         rpc_q   <= C_RESET_VECTOR;
         outst_q <= '0;
         disc_q  <= '0;
      end else if (clk_en_i) begin
         run_q   <= 1'b1;
         fpc_q   <= fpc_d;
         rpc_q   <= rpc_d;
         outst_q <= outst_d;
         disc_q  <= disc_d;
      end
   end

   pfu_fifo #(
      .W     (EW),
      .DEPTH (C_FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .resetb_i (resetb_i),
      .clk_en_i (clk_en_i),
      .flush_i  (redirect),
      .push_i   (push),
      .wdata_i  (fifo_wdata),
      .pop_i    (fifo_pop),
      .rdata_o  (fifo_rdata),
      .count_o  (fifo_count),
      .empty_o  (fifo_empty),
      .full_o   (fifo_full)
   );

endmodule

// File: tb/tb_pfu.sv
// Directed bench for the prefetch unit with a one-cycle-latency bus model.
module tb_pfu;

   logic        clk_i;
   logic        resetb_i;
   logic        clk_en_i;
   logic        pc_ready_o;
   logic        pc_wr_i;
   logic [31:0] pc_i;
   logic        ireqvalid_o;
   logic        ireqready_i;
   logic [31:0] ireqaddr_o;
   logic        irspvalid_i;
   logic [31:0] irspdata_i;
   logic        irsperr_i;
   logic        ids_dav_o;
   logic        ids_ack_i;
   logic [31:0] ids_ins_o;
   logic [31:0] ids_pc_o;
   logic        ids_ferr_o;

   pfu dut (
      .clk_i       (clk_i),
      .resetb_i    (resetb_i),
      .clk_en_i    (clk_en_i),
      .pc_ready_o  (pc_ready_o),
      .pc_wr_i     (pc_wr_i),
      .pc_i        (pc_i),
      .ireqvalid_o (ireqvalid_o),
      .ireqready_i (ireqready_i),
      .ireqaddr_o  (ireqaddr_o),
      .irspvalid_i (irspvalid_i),
      .irspdata_i  (irspdata_i),
      .irsperr_i   (irsperr_i),
      .ids_dav_o   (ids_dav_o),
      .ids_ack_i   (ids_ack_i),
      .ids_ins_o   (ids_ins_o),
      .ids_pc_o    (ids_pc_o),
      .ids_ferr_o  (ids_ferr_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int          vectors = 0;
   int          errors  = 0;
   int          acc_cnt = 0;
   logic        rsp_en;
   logic [31:0] err_addr;
   logic [31:0] bq[$];
   logic [31:0] dq_pc[$];
   logic [31:0] dq_ins[$];
   logic        dq_err[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   // A push that would land in a full buffer without a simultaneous pop.
   always @(posedge clk_i) begin
      if (resetb_i && clk_en_i && dut.push_req && dut.fifo_full && !dut.fifo_pop) begin
         errors++;
         $display("FAIL fifo_overflow: push into full buffer at time %0t", $time);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // One clock: present bus response, record handshakes, advance the bus model.
   task automatic tick();
      logic        acc, rsp, redir, pop;
      logic [31:0] a;
      if (rsp_en && bq.size() > 0) begin
         irspvalid_i = 1'b1;
         irspdata_i  = mem_word(bq[0]);
         irsperr_i   = (bq[0] == err_addr);
      end else begin
         irspvalid_i = 1'b0;
         irspdata_i  = '0;
         irsperr_i   = 1'b0;
      end
      #1;
      acc   = clk_en_i & ireqvalid_o & ireqready_i;
      rsp   = clk_en_i & irspvalid_i;
      redir = clk_en_i & pc_wr_i & pc_ready_o;
      pop   = clk_en_i & ids_dav_o & ids_ack_i & ~redir;
      a     = ireqaddr_o;
      if (pop) begin
         dq_pc.push_back(ids_pc_o);
         dq_ins.push_back(ids_ins_o);
         dq_err.push_back(ids_ferr_o);
      end
      @(posedge clk_i);
      #1;
      if (rsp) void'(bq.pop_front());
      if (acc) begin
         bq.push_back(a);
         acc_cnt++;
      end
   endtask

   task automatic clear_log();
      dq_pc.delete();
      dq_ins.delete();
      dq_err.delete();
   endtask

   task automatic do_reset();
      resetb_i    = 1'b0;
      clk_en_i    = 1'b1;
      pc_wr_i     = 1'b0;
      pc_i        = '0;
      ireqready_i = 1'b1;
      irspvalid_i = 1'b0;
      irspdata_i  = '0;
      irsperr_i   = 1'b0;
      ids_ack_i   = 1'b0;
      rsp_en      = 1'b1;
      err_addr    = 32'hFFFF_FFFF;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      bq.delete();
      clear_log();
      acc_cnt  = 0;
      resetb_i = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      resetb_i    = 1'b0;
      clk_en_i    = 1'b1;
      pc_wr_i     = 1'b0;
      pc_i        = '0;
      ireqready_i = 1'b1;
      irspvalid_i = 1'b0;
      irspdata_i  = '0;
      irsperr_i   = 1'b0;
      ids_ack_i   = 1'b0;
      rsp_en      = 1'b1;
      err_addr    = 32'hFFFF_FFFF;
      #3;
      vectors++; if (ids_dav_o !== 1'b0) begin errors++; $display("FAIL rst_dav: got %b want 0", ids_dav_o); end
      vectors++; if (ireqvalid_o !== 1'b0) begin errors++; $display("FAIL rst_reqvalid: got %b want 0", ireqvalid_o); end
      @(posedge clk_i); #1;
      resetb_i = 1'b1;
      bq.delete(); clear_log(); acc_cnt = 0;
      #1;
      vectors++; if (pc_ready_o !== 1'b1) begin errors++; $display("FAIL rst_pcready: got %b want 1", pc_ready_o); end
      vectors++; if (ireqvalid_o !== 1'b0) begin errors++; $display("FAIL rst_first_reqvalid: got %b want 0", ireqvalid_o); end
      tick();
      vectors++; if (ireqvalid_o !== 1'b1) begin errors++; $display("FAIL rst_reqvalid_up: got %b want 1", ireqvalid_o); end
      vectors++; if (ireqaddr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 00000000", ireqaddr_o); end
      ids_ack_i = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      vectors++; if (ids_dav_o !== 1'b1) begin errors++; $display("FAIL rst_pre_dav: got %b want 1", ids_dav_o); end
      #2;
      resetb_i = 1'b0;
      #1;
      vectors++; if (ids_dav_o !== 1'b0) begin errors++; $display("FAIL rst_async_dav: got %b want 0", ids_dav_o); end
      vectors++; if (ireqvalid_o !== 1'b0) begin errors++; $display("FAIL rst_async_reqvalid: got %b want 0", ireqvalid_o); end
      @(posedge clk_i); #1;
      resetb_i = 1'b1;
      bq.delete(); clear_log(); acc_cnt = 0;
      tick();
      vectors++; if (ireqaddr_o !== 32'h0) begin errors++; $display("FAIL rst_async_addr: got %h want 00000000", ireqaddr_o); end
   endtask

   task automatic test_stream();
      int   gaps;
      logic seen;
      do_reset();
      ids_ack_i = 1'b1;
      gaps = 0;
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (seen && !ids_dav_o) gaps++;
         if (ids_dav_o) seen = 1'b1;
      end
      vectors++; if (gaps !== 0) begin errors++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
      vectors++; if (dq_pc.size() !== 13) begin errors++; $display("FAIL stream_count: got %0d want 13", dq_pc.size()); end
      for (int i = 0; i < 13 && i < dq_pc.size(); i++) begin
         vectors++;
         if (dq_pc[i] !== 32'(4 * i) || dq_ins[i] !== mem_word(32'(4 * i)) || dq_err[i] !== 1'b0) begin
            errors++;
            $display("FAIL stream_entry%0d: got pc=%h ins=%h err=%b want pc=%h ins=%h err=0",
                     i, dq_pc[i], dq_ins[i], dq_err[i], 32'(4 * i), mem_word(32'(4 * i)));
         end
      end
   endtask

   task automatic test_credit();
      do_reset();
      ids_ack_i = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      vectors++; if (acc_cnt !== 4) begin errors++; $display("FAIL credit_reqs: got %0d want 4", acc_cnt); end
      vectors++; if (ireqvalid_o !== 1'b0) begin errors++; $display("FAIL credit_stop: got %b want 0", ireqvalid_o); end
      vectors++; if (ids_pc_o !== 32'h0) begin errors++; $display("FAIL credit_head: got %h want 00000000", ids_pc_o); end
      ids_ack_i = 1'b1;
      tick();
      ids_ack_i = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      vectors++; if (acc_cnt !== 5) begin errors++; $display("FAIL credit_one_more: got %0d want 5", acc_cnt); end
      vectors++; if (ireqvalid_o !== 1'b0) begin errors++; $display("FAIL credit_stop2: got %b want 0", ireqvalid_o); end
      vectors++; if (ids_pc_o !== 32'h4) begin errors++; $display("FAIL credit_head2: got %h want 00000004", ids_pc_o); end
   endtask

   task automatic test_stall_redirect();
      logic found;
      do_reset();
      ids_ack_i = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (ireqaddr_o == 32'h10) found = 1'b1;
      end
      vectors++; if (!found) begin errors++; $display("FAIL stall_reach: addr %h never reached 00000010", ireqaddr_o); end
      ireqready_i = 1'b0;
      pc_wr_i     = 1'b1;
      pc_i        = 32'h200;
      #1;
      vectors++; if (pc_ready_o !== 1'b0) begin errors++; $display("FAIL stall_pcready: got %b want 0", pc_ready_o); end
      vectors++; if (ireqvalid_o !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", ireqvalid_o); end
      for (int i = 0; i < 3; i++) tick();
      vectors++; if (ireqaddr_o !== 32'h10) begin errors++; $display("FAIL stall_addr_hold: got %h want 00000010", ireqaddr_o); end
      vectors++; if (pc_ready_o !== 1'b0) begin errors++; $display("FAIL stall_pcready_hold: got %b want 0", pc_ready_o); end
      ireqready_i = 1'b1;
      #1;
      vectors++; if (pc_ready_o !== 1'b1) begin errors++; $display("FAIL stall_pcready_up: got %b want 1", pc_ready_o); end
      tick();
      pc_wr_i = 1'b0;
      clear_log();
      vectors++; if (ireqaddr_o !== 32'h200) begin errors++; $display("FAIL stall_new_addr: got %h want 00000200", ireqaddr_o); end
      vectors++; if (ids_dav_o !== 1'b0) begin errors++; $display("FAIL stall_flush_dav: got %b want 0", ids_dav_o); end
      for (int i = 0; i < 10; i++) tick();
      vectors++; if (dq_pc.size() !== 8) begin errors++; $display("FAIL stall_count: got %0d want 8", dq_pc.size()); end
      for (int i = 0; i < 8 && i < dq_pc.size(); i++) begin
         vectors++;
         if (dq_pc[i] !== 32'h200 + 32'(4 * i) || dq_ins[i] !== mem_word(32'h200 + 32'(4 * i))) begin
            errors++;
            $display("FAIL stall_entry%0d: got pc=%h ins=%h want pc=%h", i, dq_pc[i], dq_ins[i], 32'h200 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_discard();
      logic found;
      do_reset();
      ids_ack_i = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (ireqaddr_o == 32'h20) found = 1'b1;
      end
      vectors++; if (!found) begin errors++; $display("FAIL disc_reach: addr %h never reached 00000020", ireqaddr_o); end
      // Leave exactly one entry (0x1C) in the buffer and nothing in flight.
      ids_ack_i   = 1'b0;
      ireqready_i = 1'b0;
      tick();
      ids_ack_i = 1'b1;
      tick();
      ids_ack_i   = 1'b0;
      ireqready_i = 1'b1;
      rsp_en      = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      vectors++; if (ireqaddr_o !== 32'h2C) begin errors++; $display("FAIL disc_addr: got %h want 0000002c", ireqaddr_o); end
      vectors++; if (ireqvalid_o !== 1'b0) begin errors++; $display("FAIL disc_credit: got %b want 0", ireqvalid_o); end
      vectors++; if (ids_pc_o !== 32'h1C) begin errors++; $display("FAIL disc_head: got %h want 0000001c", ids_pc_o); end
      pc_wr_i = 1'b1;
      pc_i    = 32'h100;
      tick();
      pc_wr_i = 1'b0;
      clear_log();
      vectors++; if (ids_dav_o !== 1'b0) begin errors++; $display("FAIL disc_flush_dav: got %b want 0", ids_dav_o); end
      rsp_en    = 1'b1;
      ids_ack_i = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      vectors++; if (dq_pc.size() !== 8) begin errors++; $display("FAIL disc_count: got %0d want 8", dq_pc.size()); end
      for (int i = 0; i < 8 && i < dq_pc.size(); i++) begin
         vectors++;
         if (dq_pc[i] !== 32'h100 + 32'(4 * i) || dq_ins[i] !== mem_word(32'h100 + 32'(4 * i))) begin
            errors++;
            $display("FAIL disc_entry%0d: got pc=%h ins=%h want pc=%h", i, dq_pc[i], dq_ins[i], 32'h100 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      ids_ack_i = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      pc_wr_i = 1'b1;
      pc_i    = 32'h300;
      tick();
      pc_wr_i = 1'b0;
      clear_log();
      vectors++; if (ids_dav_o !== 1'b0) begin errors++; $display("FAIL same_flush_dav: got %b want 0", ids_dav_o); end
      vectors++; if (ireqaddr_o !== 32'h300) begin errors++; $display("FAIL same_addr: got %h want 00000300", ireqaddr_o); end
      for (int i = 0; i < 10; i++) tick();
      vectors++; if (dq_pc.size() !== 8) begin errors++; $display("FAIL same_count: got %0d want 8", dq_pc.size()); end
      for (int i = 0; i < 8 && i < dq_pc.size(); i++) begin
         vectors++;
         if (dq_pc[i] !== 32'h300 + 32'(4 * i) || dq_ins[i] !== mem_word(32'h300 + 32'(4 * i))) begin
            errors++;
            $display("FAIL same_entry%0d: got pc=%h ins=%h want pc=%h", i, dq_pc[i], dq_ins[i], 32'h300 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      ireqready_i = 1'b0;
      #1;
      vectors++; if (pc_ready_o !== 1'b1) begin errors++; $display("FAIL wrap_first_pcready: got %b want 1", pc_ready_o); end
      pc_wr_i = 1'b1;
      pc_i    = 32'hFFFF_FFF9;
      tick();
      pc_wr_i     = 1'b0;
      ireqready_i = 1'b1;
      ids_ack_i   = 1'b1;
      #1;
      vectors++; if (ireqaddr_o !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_addr: got %h want fffffff8", ireqaddr_o); end
      for (int i = 0; i < 8; i++) tick();
      vectors++; if (dq_pc.size() !== 6) begin errors++; $display("FAIL wrap_count: got %0d want 6", dq_pc.size()); end
      for (int i = 0; i < 6 && i < dq_pc.size(); i++) begin
         vectors++;
         if (dq_pc[i] !== 32'hFFFF_FFF8 + 32'(4 * i)) begin
            errors++;
            $display("FAIL wrap_entry%0d: got pc=%h want %h", i, dq_pc[i], 32'hFFFF_FFF8 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_bus_error();
      do_reset();
      err_addr  = 32'h8;
      ids_ack_i = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      vectors++; if (dq_pc.size() < 4) begin errors++; $display("FAIL berr_count: got %0d want >=4", dq_pc.size()); end
      if (dq_pc.size() >= 4) begin
         vectors++; if (dq_pc[1] !== 32'h4 || dq_err[1] !== 1'b0) begin errors++; $display("FAIL berr_prev: got pc=%h err=%b want pc=00000004 err=0", dq_pc[1], dq_err[1]); end
         vectors++; if (dq_pc[2] !== 32'h8 || dq_err[2] !== 1'b1 || dq_ins[2] !== mem_word(32'h8)) begin errors++; $display("FAIL berr_entry: got pc=%h err=%b ins=%h want pc=00000008 err=1", dq_pc[2], dq_err[2], dq_ins[2]); end
         vectors++; if (dq_pc[3] !== 32'hC || dq_err[3] !== 1'b0) begin errors++; $display("FAIL berr_next: got pc=%h err=%b want pc=0000000c err=0", dq_pc[3], dq_err[3]); end
      end
   endtask

   task automatic test_clk_en();
      do_reset();
      ids_ack_i = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      clk_en_i = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      vectors++; if (ireqaddr_o !== 32'h14) begin errors++; $display("FAIL cken_addr: got %h want 00000014", ireqaddr_o); end
      vectors++; if (ids_pc_o !== 32'hC || ids_dav_o !== 1'b1) begin errors++; $display("FAIL cken_head: got pc=%h dav=%b want pc=0000000c dav=1", ids_pc_o, ids_dav_o); end
      vectors++; if (acc_cnt !== 5) begin errors++; $display("FAIL cken_reqs: got %0d want 5", acc_cnt); end
      clk_en_i = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      vectors++; if (dq_pc.size() !== 9) begin errors++; $display("FAIL cken_count: got %0d want 9", dq_pc.size()); end
      for (int i = 0; i < 9 && i < dq_pc.size(); i++) begin
         vectors++;
         if (dq_pc[i] !== 32'(4 * i)) begin
            errors++;
            $display("FAIL cken_entry%0d: got pc=%h want %h", i, dq_pc[i], 32'(4 * i));
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_credit();
      test_stall_redirect();
      test_discard();
      test_same_cycle();
      test_wrap();
      test_bus_error();
      test_clk_en();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
